// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states,
// decoder jump codes and the default reset PC.
package ifetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_FETCH  = 2'b01,
        S_SQUASH = 2'b10
    } fetch_state_e;

    // Jump code driven by the decoder; 2'b11 is treated like JMP_NONE.
    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_J    = 2'b01;
    localparam logic [1:0] JMP_JR   = 2'b10;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ifetch_pc_next.sv
// Next-PC selection for the fetch stage. Detects a redirect from the
// instruction held in IF/ID and picks the redirect target, otherwise
// advances past an accepted fetch or holds the current PC.
module ifetch_pc_next
    import ifetch_pkg::*;
#(
    parameter int n = 32
) (
    input  logic [n-1:0]  pc,
    input  logic [n-29:0] pc_plus4_hi,
    input  logic [25:0]   instr_index,
    input  logic          valid,
    input  logic [1:0]    jump,
    input  logic          pcsrc,
    input  logic [n-1:0]  branch_target,
    input  logic [n-1:0]  jr_target,
    input  logic          accept,
    output logic          redirect,
    output logic [n-1:0]  pc_inc,
    output logic [n-1:0]  next_pc
);

    logic [n-1:0] jump_target;

    // A redirect is only meaningful while IF/ID holds a live instruction;
    // kept separate from next_pc so accept can depend on it without a loop.
    assign redirect = valid && ((jump == JMP_JR) || (jump == JMP_J) || pcsrc);

    // Sequential fetch address, wrapping naturally at 2^n.
    assign pc_inc = pc + n'(4);

    // Jumps take priority over a taken branch; jr beats j.
    always_comb begin
        jump_target = branch_target;
        case (jump)
            JMP_JR:   jump_target = jr_target;
            JMP_J:    jump_target = {pc_plus4_hi, instr_index, 2'b00};
            JMP_NONE: jump_target = branch_target;
            default:  jump_target = branch_target;
        endcase
    end

    // Redirect overrides everything, then a successful fetch advances.
    always_comb begin
        next_pc = pc;
        if (redirect) begin
            next_pc = jump_target;
        end else if (accept) begin
            next_pc = pc_inc;
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: issues requests to instruction memory, loads
// the IF/ID register on an acknowledged fetch, and squashes one cycle of
// fetch after any jump or taken branch.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int          n        = 32,
    parameter logic [n-1:0] RESET_PC = n'(RESET_PC_DEFAULT)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [n-1:0]  imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    input  logic          stall,
    input  logic          pcsrc,
    input  logic [n-1:0]  branch_target,
    input  logic [1:0]    jump,
    input  logic [n-1:0]  jr_target,
    output logic [31:0]   instr,
    output logic [n-1:0]  pc_plus4,
    output logic          valid,
    output logic [5:0]    op,
    output logic [5:0]    funct
);

    fetch_state_e state_q, state_d;
    logic [n-1:0] pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [n-1:0] pc_plus4_q, pc_plus4_d;
    logic         valid_q, valid_d;

    logic         redirect;
    logic         accept;
    logic [n-1:0] pc_inc;

    ifetch_pc_next #(.n(n)) u_pc_next (
        .pc            (pc_q),
        .pc_plus4_hi   (pc_plus4_q[n-1:28]),
        .instr_index   (instr_q[25:0]),
        .valid         (valid_q),
        .jump          (jump),
        .pcsrc         (pcsrc),
        .branch_target (branch_target),
        .jr_target     (jr_target),
        .accept        (accept),
        .redirect      (redirect),
        .pc_inc        (pc_inc),
        .next_pc       (pc_d)
    );

    // Next-state and request generation; a redirect always forces a squash cycle.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  imem_req = !stall;
            S_SQUASH: state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
        if (redirect) begin
            state_d = S_SQUASH;
        end
    end

    // An ack arriving in the same cycle as a redirect belongs to the wrong path.
    assign accept = (state_q == S_FETCH) && imem_req && imem_ack && !redirect;

    // IF/ID register update: flush on redirect, load on accept, bubble when
    // fetch is free to proceed but memory has not answered, otherwise hold.
    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (redirect) begin
            instr_d = 32'h0;
            valid_d = 1'b0;
        end else if (accept) begin
            instr_d    = imem_rdata;
            pc_plus4_d = pc_inc;
            valid_d    = 1'b1;
        end else if ((state_q == S_FETCH) && !stall) begin
            valid_d = 1'b0;
        end
    end

    // State and pipeline registers; reset abandons any outstanding fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign pc_plus4  = pc_plus4_q;
    assign valid     = valid_q;
    assign op        = instr_q[31:26];
    assign funct     = instr_q[5:0];

endmodule
